// File: rtl/factor_pkg.sv
// factor_pkg: shared definitions for the factor_search block.
//   - default factor / target widths
//   - controller state encoding
//   - lowest candidate value, with and without trivial factors
package factor_pkg;

   localparam int FW_DEFAULT    = 4;
   localparam int AW_DEFAULT    = 2 * FW_DEFAULT;

   // Lowest value tried for either factor.
   localparam int LO_ALL        = 0;
   localparam int LO_NONTRIVIAL = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MUL,
      ST_CMP,
      ST_DONE
   } state_t;

   function automatic int lo_value(input bit skip_trivial);
      return skip_trivial ? LO_NONTRIVIAL : LO_ALL;
   endfunction

endpackage

// File: rtl/factor_search_mul_seq.sv
// mul_seq: FW-cycle unsigned shift-add multiplier.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   load         - capture op_a/op_b and clear the accumulator
//   step         - perform one shift-add (one partial product)
//   op_a, op_b   - FW-bit unsigned operands
//   product      - AW-bit full-width product, valid after FW steps
//   done         - high during the final step; product is complete
//                  from the following cycle onwards
module mul_seq
   import factor_pkg::*;
#(
   parameter int FW = FW_DEFAULT,
   parameter int AW = AW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          step,
   input  logic [FW-1:0] op_a,
   input  logic [FW-1:0] op_b,
   output logic [AW-1:0] product,
   output logic          done
);

   localparam int CW = $clog2(FW + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(FW - 1);

   logic [AW-1:0] mcand;
   logic [FW-1:0] mplier;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         product <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
      end else if (load) begin
         product <= '0;
         mcand   <= {{(AW-FW){1'b0}}, op_a};
         mplier  <= op_b;
         cnt     <= '0;
      end else if (step) begin
         // Multiplicand is kept AW wide so the shifted partial products
         // never lose their upper bits.
         if (mplier[0]) begin
            product <= product + mcand;
         end
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

   assign done = step && (cnt == LAST_STEP);

endmodule

// File: rtl/factor_search.sv
// factor_search: exhaustive search for a factor pair f1*f2 == start_a with
// f1 <= f2, enumerating f1 ascending (outer) and f2 ascending from f1
// (inner). Each candidate costs FW+2 cycles: LOAD, FW MUL cycles, CMP.
// Optional build macro: FACTOR_SKIP_TRIVIAL_EN -- when defined the search
// starts at 2, so only nontrivial factorizations are reported.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   start_valid/start_ready    - request handshake, start_a sampled on accept
//   start_a                    - AW-bit target product
//   res_valid/res_ready        - result handshake
//   res_found, res_f1, res_f2  - result; f1/f2 are zero when not found
//   busy                       - high whenever not idle
module factor_search
   import factor_pkg::*;
#(
   parameter int FW = FW_DEFAULT,
   parameter int AW = AW_DEFAULT   // must equal 2*FW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_valid,
   output logic          start_ready,
   input  logic [AW-1:0] start_a,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          res_found,
   output logic [FW-1:0] res_f1,
   output logic [FW-1:0] res_f2,
   output logic          busy
);

`ifdef FACTOR_SKIP_TRIVIAL_EN
   localparam bit SKIP_TRIVIAL = 1'b1;
`else
   localparam bit SKIP_TRIVIAL = 1'b0;
`endif

   localparam logic [FW-1:0] LO  = FW'(lo_value(SKIP_TRIVIAL));
   localparam logic [FW-1:0] MAX = '1;

   state_t        state, state_nx;
   logic [AW-1:0] target;
   logic [FW-1:0] i1, i2;
   logic          found;
   logic [FW-1:0] f1, f2;
   logic [AW-1:0] product;
   logic          mul_done;
   logic          load, step;
   logic          match;
   logic          last_cand;

   mul_seq #(.FW(FW), .AW(AW)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .step    (step),
      .op_a    (i1),
      .op_b    (i2),
      .product (product),
      .done    (mul_done)
   );

   assign match     = (product == target);
   assign last_cand = (i1 == MAX) && (i2 == MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      load        = 1'b0;
      step        = 1'b0;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      busy        = 1'b1;
      case (state)
         ST_IDLE: begin
            start_ready = 1'b1;
            busy        = 1'b0;
            if (start_valid) state_nx = ST_LOAD;
         end
         ST_LOAD: begin
            load     = 1'b1;
            state_nx = ST_MUL;
         end
         ST_MUL: begin
            step = 1'b1;
            if (mul_done) state_nx = ST_CMP;
         end
         ST_CMP: begin
            state_nx = (match || last_cand) ? ST_DONE : ST_LOAD;
         end
         ST_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         target <= '0;
         i1     <= '0;
         i2     <= '0;
         found  <= 1'b0;
         f1     <= '0;
         f2     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_valid) begin
                  target <= start_a;
                  i1     <= LO;
                  i2     <= LO;
               end
            end
            ST_CMP: begin
               if (match) begin
                  found <= 1'b1;
                  f1    <= i1;
                  f2    <= i2;
               end else if (i2 < MAX) begin
                  i2 <= i2 + 1'b1;
               end else if (i1 < MAX) begin
                  // Inner loop restarts at the new outer value so f1 <= f2.
                  i1 <= i1 + 1'b1;
                  i2 <= i1 + 1'b1;
               end else begin
                  found <= 1'b0;
                  f1    <= '0;
                  f2    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign res_found = found;
   assign res_f1    = f1;
   assign res_f2    = f2;

endmodule

// File: tb/tb_factor_search.sv
// tb_factor_search: self-checking bench for factor_search.
// Directed vector table, hand-written handshake/reset sequences, and
// randomized targets compared against an enumeration model.
// Honors FACTOR_SKIP_TRIVIAL_EN the same way the design does.
module tb_factor_search;

   localparam int FW    = 4;
   localparam int AW    = 8;
   localparam int MAXV  = 15;
   localparam int LIMIT = 2000;

`ifdef FACTOR_SKIP_TRIVIAL_EN
   localparam int LO = 2;
`else
   localparam int LO = 0;
`endif

   logic          clk;
   logic          rst;
   logic          start_valid;
   logic          start_ready;
   logic [AW-1:0] start_a;
   logic          res_valid;
   logic          res_ready;
   logic          res_found;
   logic [FW-1:0] res_f1;
   logic [FW-1:0] res_f2;
   logic          busy;

   factor_search #(.FW(FW), .AW(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .start_a     (start_a),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_found   (res_found),
      .res_f1      (res_f1),
      .res_f2      (res_f2),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   typedef struct {
      int a;
      bit found;
      int f1;
      int f2;
      int cyc;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Enumerate candidates in search order; the first product match wins.
   function automatic void model(input int a, output bit fnd, output int f1,
                                 output int f2, output int cyc);
      int k;
      k = 0;
      fnd = 1'b0;
      f1 = 0;
      f2 = 0;
      for (int x = LO; x <= MAXV; x++) begin
         for (int y = x; y <= MAXV; y++) begin
            if (!fnd) begin
               k++;
               if (x * y == a) begin
                  fnd = 1'b1;
                  f1 = x;
                  f2 = y;
               end
            end
         end
      end
      cyc = k * (FW + 2) + 1;
   endfunction

   // Issue one request; cycle 0 is the accept cycle. Optionally pulse a
   // stray request at cycle glitch_at, or assert reset at cycle rst_at.
   task automatic run_txn(input int a, input int glitch_at, input int rst_at,
                          output bit got_found, output int got_f1,
                          output int got_f2, output int got_cyc,
                          output bit aborted);
      int cyc;
      check("accept_ready", int'(start_ready), 1);
      start_valid = 1'b1;
      start_a     = 8'(a);
      @(posedge clk); #1;
      start_valid = 1'b0;
      start_a     = 8'($urandom_range(0, 255));
      cyc     = 1;
      aborted = 1'b0;
      while (!res_valid && cyc < LIMIT) begin
         if (cyc == glitch_at) begin
            start_valid = 1'b1;
            start_a     = 8'd6;
         end
         if (cyc == rst_at) begin
            check("busy_before_rst", int'(busy), 1);
            rst = 1'b1;
         end
         @(posedge clk); #1;
         start_valid = 1'b0;
         if (rst) begin
            rst     = 1'b0;
            aborted = 1'b1;
            break;
         end
         cyc++;
      end
      if (!aborted) check("res_valid_in_time", int'(res_valid), 1);
      got_found = res_found;
      got_f1    = int'(res_f1);
      got_f2    = int'(res_f2);
      got_cyc   = cyc;
   endtask

   // Hold the result for 'hold' cycles, then accept it and expect IDLE.
   task automatic consume(input int hold, input bit ef, input int e1, input int e2);
      res_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_valid", int'(res_valid), 1);
         check("hold_found", int'(res_found), int'(ef));
         check("hold_f1", int'(res_f1), e1);
         check("hold_f2", int'(res_f2), e2);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check("idle_start_ready", int'(start_ready), 1);
      check("idle_busy", int'(busy), 0);
      check("idle_res_valid", int'(res_valid), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_start_ready"}, int'(start_ready), 1);
      check({tag, "_res_valid"}, int'(res_valid), 0);
      check({tag, "_res_found"}, int'(res_found), 0);
      check({tag, "_res_f1"}, int'(res_f1), 0);
      check({tag, "_res_f2"}, int'(res_f2), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      bit gf, ab, mf;
      int g1, g2, gc, m1, m2, mc, a;

`ifdef FACTOR_SKIP_TRIVIAL_EN
      vecs[0] = '{15,  1'b1, 3,  5,  103};
      vecs[1] = '{13,  1'b0, 0,  0,  631};
      vecs[2] = '{225, 1'b1, 15, 15, 631};
      vecs[3] = '{6,   1'b1, 2,  3,  13};
      vecs[4] = '{4,   1'b1, 2,  2,  7};
      vecs[5] = '{0,   1'b0, 0,  0,  631};
      vecs[6] = '{1,   1'b0, 0,  0,  631};
`else
      vecs[0] = '{15,  1'b1, 1,  15, 187};
      vecs[1] = '{0,   1'b1, 0,  0,  7};
      vecs[2] = '{1,   1'b1, 1,  1,  103};
      vecs[3] = '{13,  1'b1, 1,  13, 175};
      vecs[4] = '{6,   1'b1, 1,  6,  133};
      vecs[5] = '{225, 1'b1, 15, 15, 817};
      vecs[6] = '{255, 1'b0, 0,  0,  817};
`endif

      rst         = 1'b1;
      start_valid = 1'b0;
      start_a     = '0;
      res_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed vectors
      for (int v = 0; v < 7; v++) begin
         run_txn(vecs[v].a, 0, 0, gf, g1, g2, gc, ab);
         check("vec_found", int'(gf), int'(vecs[v].found));
         check("vec_f1", g1, vecs[v].f1);
         check("vec_f2", g2, vecs[v].f2);
         check("vec_cycle", gc, vecs[v].cyc);
         consume(v % 3, vecs[v].found, vecs[v].f1, vecs[v].f2);
      end

      // Stray request during MUL of the first candidate is ignored
      model(15, mf, m1, m2, mc);
      run_txn(15, 3, 0, gf, g1, g2, gc, ab);
      check("glitch_found", int'(gf), int'(mf));
      check("glitch_f1", g1, m1);
      check("glitch_f2", g2, m2);
      check("glitch_cycle", gc, mc);

      // Result held for 10 cycles, then released
      consume(10, mf, m1, m2);

      // Reset mid-MUL of candidate 5, then a fresh request
      run_txn(255, 0, 27, gf, g1, g2, gc, ab);
      check("rst_mid_aborted", int'(ab), 1);
      check_reset_outputs("rst_mid");
      model(6, mf, m1, m2, mc);
      run_txn(6, 0, 0, gf, g1, g2, gc, ab);
      check("after_rst_found", int'(gf), int'(mf));
      check("after_rst_f1", g1, m1);
      check("after_rst_f2", g2, m2);
      check("after_rst_cycle", gc, mc);
      consume(0, mf, m1, m2);

      // Reset while a result is pending in DONE discards it
      run_txn(4, 0, 0, gf, g1, g2, gc, ab);
      check("done_before_rst", int'(res_valid), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset_outputs("rst_done");

      // Randomized targets
      for (int r = 0; r < 24; r++) begin
         if ($urandom_range(0, 1) == 1)
            a = int'($urandom_range(0, 15)) * int'($urandom_range(0, 15));
         else
            a = int'($urandom_range(0, 255));
         model(a, mf, m1, m2, mc);
         run_txn(a, 0, 0, gf, g1, g2, gc, ab);
         check("rand_found", int'(gf), int'(mf));
         check("rand_f1", g1, m1);
         check("rand_f2", g2, m2);
         check("rand_cycle", gc, mc);
         consume(int'($urandom_range(0, 3)), mf, m1, m2);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/factor_search.md
FACTOR_SEARCH -- requirements
Module: factor_search

Interface
REQ-001 SHALL have parameter FW, default 4, factor operand width.
REQ-002 SHALL have parameter AW, default 8, target width; AW SHALL equal 2*FW.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start_valid, input, 1, request to search the factors of start_a.
REQ-006 SHALL have port start_ready, output, 1, block idle and able to accept a request.
REQ-007 SHALL have port start_a, input, AW, target product, sampled on accept.
REQ-008 SHALL have port res_valid, output, 1, result available.
REQ-009 SHALL have port res_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port res_found, output, 1, a factor pair was found.
REQ-011 SHALL have ports res_f1 and res_f2, output, FW each, found pair with res_f1 <= res_f2; zero when res_found=0.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement the states IDLE, LOAD, MUL, CMP and DONE.
REQ-014 IDLE: start_ready=1; start_valid=1 SHALL latch start_a and set i1=i2=LO, then go to LOAD; LO=0, or LO=2 under REQ-026.
REQ-015 LOAD, one cycle: SHALL load the multiplier with (i1,i2); go to MUL.
REQ-016 MUL: exactly FW cycles of shift-add, one partial product per cycle; then go to CMP.
REQ-017 CMP, one cycle: product == latched target SHALL go to DONE with found=1, f1=i1, f2=i2.
REQ-018 CMP mismatch: if i2<MAX, i2++; else if i1<MAX, i1++ and i2=i1+1; else go to DONE with found=0; otherwise go to LOAD. MAX=2^FW-1.
REQ-019 Enumeration order SHALL be i1 ascending (outer), i2 ascending from i1 (inner); the first match in this order wins.
REQ-020 Each candidate SHALL take FW+2 cycles. For accept in cycle 0, candidate k ends CMP in cycle k*(FW+2); res_valid rises in cycle k*(FW+2)+1.
REQ-021 DONE: res_valid=1, result outputs stable; res_ready=1 SHALL return to IDLE next cycle. Result outputs are don't-care outside DONE.
REQ-022 start_valid while busy SHALL be ignored and not queued; start_a changes while busy SHALL have no effect.
REQ-023 The product SHALL be computed to the full AW bits with no truncation; the compare is unsigned.

Reset
REQ-024 rst=1 SHALL force IDLE from any state, including mid-MUL and DONE, discarding any pending result.
REQ-025 Reset values SHALL be: start_ready=1, res_valid=0, res_found=0, res_f1=0, res_f2=0, busy=0; counters, target and multiplier registers 0.

Configuration
REQ-026 Macro FACTOR_SKIP_TRIVIAL_EN: when defined, LO=2, so 0 and 1 are never tried and only nontrivial factorizations are reported. When undefined, LO=0.

Structure
REQ-027 Shared package factor_pkg SHALL hold FW/AW defaults, the state enum type and the LO constants.
REQ-028 Sub-module mul_seq SHALL implement the FW-cycle shift-add multiplier with ports load, operands, product and done.

Verification
REQ-029 Macro defined, a=15: res_found=1, f1=3, f2=5, res_valid at cycle 103 (candidate 17).
REQ-030 Macro undefined, a=15: found (1,15) at candidate 31, cycle 187; a=0: found (0,0) at candidate 1, cycle 7.
REQ-031 Macro defined, a=13 (prime): res_found=0, f1=f2=0, res_valid at cycle 631 (105 candidates); a=225: found (15,15) at cycle 631.
REQ-032 start_valid pulsed with a new start_a during MUL: ignored; the original result is unchanged.
REQ-033 res_ready held low for 10 cycles in DONE: outputs stable; res_ready=1 leads to IDLE and start_ready=1 the next cycle.
REQ-034 rst asserted during MUL of candidate 5: next cycle IDLE with all outputs at reset values; a new a=6 request (macro defined) yields (2,3) at cycle 13.
